dc_router_param: RTL and testbench

DC_ROUTER_PARAM -- requirements
Module: dc_router_param

---
 rtl/dc_router_pkg.sv | 18 +
 rtl/dc_ch_mux.sv | 25 ++
 rtl/dc_router_param.sv | 123 ++++++++++++
 tb/tb_dc_router_param.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_router_pkg.sv
// rtl/dc_router_pkg.sv - shared state encoding, opcode constant and default sizes for the DMA channel router
package dc_router_pkg;

    localparam int DEF_N_CH   = 3;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_ADDR_W = 32;

    localparam logic [3:0] OPC_INVALID = 4'd0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        PUSH  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/dc_ch_mux.sv
// rtl/dc_ch_mux.sv - one-hot decode of the latched channel and selection of its from-FIFO head word
module dc_ch_mux
    import dc_router_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [3:0]             sel,
    input  logic [N_CH*DATA_W-1:0] ch_data_in,
    output logic [N_CH-1:0]        sel_oh,
    output logic [DATA_W-1:0]      sel_data
);

    always_comb begin
        sel_oh   = '0;
        sel_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == 4'(k)) begin
                sel_oh[k] = 1'b1;
                sel_data  = ch_data_in[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/dc_router_param.sv
// rtl/dc_router_param.sv - moves a RAM block through a selected accelerator channel and writes the result back
module dc_router_param
    import dc_router_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             instruction,
    input  logic [ADDR_W-1:0]      offset,
    input  logic [ADDR_W-1:0]      dest_offset,
    input  logic [ADDR_W-1:0]      filesize,
    input  logic                   abort,
    output logic                   busy,
    output logic                   acc_done,
    output logic                   cmd_err,
    output logic [N_CH-1:0]        ch_enable,
    output logic [N_CH-1:0]        put_req,
    output logic [N_CH-1:0]        get_req,
    input  logic [N_CH-1:0]        to_full,
    input  logic [N_CH-1:0]        from_empty,
    output logic [DATA_W-1:0]      ch_data_out,
    input  logic [N_CH*DATA_W-1:0] ch_data_in,
    output logic                   ram_read_enable,
    output logic                   ram_write_enable,
    output logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      ram_rdata,
    output logic [DATA_W-1:0]      ram_wdata
);

    state_t              state, state_nx;
    logic [3:0]          sel_q;
    logic [ADDR_W-1:0]   offset_q, dest_q, size_q, rd_cnt, wr_cnt;
    logic [DATA_W-1:0]   hold_q, mux_data;
    logic                push_first, cmd_err_q;
    logic [N_CH-1:0]     sel_oh;
    logic                cmd_valid, accept, sel_full, sel_empty, in_xfer, do_put, do_get;

    dc_ch_mux #(.N_CH(N_CH), .DATA_W(DATA_W)) u_ch_mux (
        .sel        (sel_q),
        .ch_data_in (ch_data_in),
        .sel_oh     (sel_oh),
        .sel_data   (mux_data)
    );

    assign cmd_valid = (instruction != OPC_INVALID) && (32'(instruction) <= 32'(N_CH));
    assign accept    = (state == IDLE) && start && cmd_valid;
    assign sel_full  = |(to_full & sel_oh);
    assign sel_empty = |(from_empty & sel_oh);
    assign in_xfer   = (state == RD) || (state == PUSH) || (state == STORE);
    assign do_put    = (state == PUSH) && !sel_full;
    assign do_get    = (state == STORE) && !sel_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sel_q      <= '0;
            offset_q   <= '0;
            dest_q     <= '0;
            size_q     <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            hold_q     <= '0;
            push_first <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            cmd_err_q  <= ((state == IDLE) && start && !cmd_valid) || (in_xfer && abort);
            // RAM data lands in the first PUSH cycle; keep it for any back-pressure stall
            push_first <= (state == RD);
            if ((state == PUSH) && push_first)
                hold_q <= ram_rdata;
            if (accept) begin
                sel_q    <= instruction - 4'd1;
                offset_q <= offset;
                dest_q   <= dest_offset;
                size_q   <= filesize;
                rd_cnt   <= '0;
                wr_cnt   <= '0;
            end
            if (do_put)
                rd_cnt <= rd_cnt + ADDR_W'(1);
            if (do_get)
                wr_cnt <= wr_cnt + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = (filesize == '0) ? DONE : RD;
            RD:    state_nx = PUSH;
            PUSH:  if (do_put) state_nx = (rd_cnt < size_q - ADDR_W'(1)) ? RD : STORE;
            STORE: if (do_get && (wr_cnt == size_q - ADDR_W'(1))) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (in_xfer && abort)
            state_nx = IDLE;
    end

    always_comb begin
        busy             = (state != IDLE);
        acc_done         = (state == DONE);
        cmd_err          = cmd_err_q;
        ch_enable        = in_xfer ? sel_oh : '0;
        put_req          = do_put ? sel_oh : '0;
        get_req          = do_get ? sel_oh : '0;
        ram_read_enable  = (state == RD);
        ram_write_enable = do_get;
        ch_data_out      = do_put ? (push_first ? ram_rdata : hold_q) : '0;
        ram_wdata        = do_get ? mux_data : '0;
        addr             = '0;
        if (state == RD)
            addr = offset_q + rd_cnt;
        else if (do_get)
            addr = dest_q + wr_cnt;
    end

endmodule

// File: tb/tb_dc_router_param.sv
// tb/tb_dc_router_param.sv - directed scoreboard bench with RAM and inverting loopback accelerator models
module tb_dc_router_param;

    logic         clk = 1'b0;
    logic         reset, start, abort;
    logic [3:0]   instruction;
    logic [31:0]  offset, dest_offset, filesize, addr;
    logic         busy, acc_done, cmd_err, ram_read_enable, ram_write_enable;
    logic [2:0]   ch_enable, put_req, get_req, to_full, from_empty;
    logic [127:0] ch_data_out, ram_wdata;
    logic [127:0] ram_rdata = '0;
    logic [383:0] ch_data_in;

    logic         flush, tog_en;
    logic         tog = 1'b0;
    logic [127:0] fmem [3][64];
    logic [6:0]   wp [3];
    logic [6:0]   rp [3];

    logic [31:0]  exp_rd [64];
    logic [127:0] exp_put [64];
    logic [31:0]  exp_wa [64];
    logic [127:0] exp_wd [64];
    logic [2:0]   exp_oh;
    int ep, mr, mp, mw, n_done, n_err, n_get1, n_stall;
    int total = 0;
    int bad = 0;
    bit busy_seen, ch_seen;

    dc_router_param dut (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction),
        .offset(offset), .dest_offset(dest_offset), .filesize(filesize), .abort(abort),
        .busy(busy), .acc_done(acc_done), .cmd_err(cmd_err), .ch_enable(ch_enable),
        .put_req(put_req), .get_req(get_req), .to_full(to_full), .from_empty(from_empty),
        .ch_data_out(ch_data_out), .ch_data_in(ch_data_in),
        .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
        .addr(addr), .ram_rdata(ram_rdata), .ram_wdata(ram_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rdf(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1234_5678};
    endfunction

    // RAM with one-cycle read latency, and per-channel accelerators that return ~data through a FWFT FIFO
    always @(posedge clk) begin
        ram_rdata <= ram_read_enable ? rdf(addr) : '0;
        tog       <= ~tog;
        for (int k = 0; k < 3; k++) begin
            if (flush) begin
                wp[k] <= '0;
                rp[k] <= '0;
            end else begin
                if (put_req[k]) begin
                    fmem[k][wp[k][5:0]] <= ~ch_data_out;
                    wp[k] <= wp[k] + 7'd1;
                end
                if (get_req[k])
                    rp[k] <= rp[k] + 7'd1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            ch_data_in[k*128 +: 128] = fmem[k][rp[k][5:0]];
            from_empty[k]            = (wp[k] == rp[k]) || (tog_en && tog);
        end
    end

    task automatic chk(input string tag, input logic [163:0] obs, input logic [163:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            chk("rw_excl", 164'(ram_read_enable & ram_write_enable), 164'd0);
            chk("put_onehot", 164'($onehot0(put_req)), 164'd1);
            chk("get_onehot", 164'($onehot0(get_req)), 164'd1);
            chk("get_while_empty", 164'(get_req & from_empty), 164'd0);
            if (ram_read_enable) begin
                chk("rd_addr", 164'(addr), 164'(exp_rd[mr % 64]));
                mr++;
            end
            if (put_req != 3'b0) begin
                chk("put", {put_req, ch_data_out}, {exp_oh, exp_put[mp % 64]});
                mp++;
            end
            if (ram_write_enable) begin
                chk("wr", {get_req, addr, ram_wdata}, {exp_oh, exp_wa[mw % 64], exp_wd[mw % 64]});
                mw++;
            end
            if (acc_done) n_done++;
            if (cmd_err) n_err++;
            if (get_req[1]) n_get1++;
            if ((to_full & ch_enable) != 3'b0 && put_req == 3'b0 && !ram_read_enable) n_stall++;
            if (busy) busy_seen = 1'b1;
            if (ch_enable != 3'b0) ch_seen = 1'b1;
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ep = 0; mr = 0; mp = 0; mw = 0;
        n_done = 0; n_err = 0; n_get1 = 0; n_stall = 0;
        busy_seen = 1'b0; ch_seen = 1'b0;
    endtask

    task automatic issue(input logic [3:0] ins, input logic [31:0] off, input logic [31:0] dst, input logic [31:0] sz);
        case (ins)
            4'd1:    exp_oh = 3'b001;
            4'd2:    exp_oh = 3'b010;
            4'd3:    exp_oh = 3'b100;
            default: exp_oh = 3'b000;
        endcase
        if (exp_oh != 3'b0) begin
            for (int i = 0; i < int'(sz); i++) begin
                exp_rd[ep]  = off + 32'(i);
                exp_put[ep] = rdf(off + 32'(i));
                exp_wa[ep]  = dst + 32'(i);
                exp_wd[ep]  = ~rdf(off + 32'(i));
                ep++;
            end
        end
        instruction = ins; offset = off; dest_offset = dst; filesize = sz;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int b = 0;
        while (n_done == 0 && n_err == 0 && b < 200) begin
            tick();
            b++;
        end
        chk({tag, "_timeout"}, 164'(b < 200), 164'd1);
        chk({tag, "_done"}, 164'(n_done), 164'd1);
        chk({tag, "_err"}, 164'(n_err), 164'd0);
        chk({tag, "_reads"}, 164'(mr), 164'(ep));
        chk({tag, "_puts"}, 164'(mp), 164'(ep));
        chk({tag, "_writes"}, 164'(mw), 164'(ep));
        tick();
        chk({tag, "_idle"}, 164'({busy, acc_done}), 164'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 164'({busy, acc_done, cmd_err, ch_enable, put_req, get_req,
                                ram_read_enable, ram_write_enable, addr}), 164'd0);
        chk({tag, "_wdata"}, 164'(ram_wdata), 164'd0);
        chk({tag, "_cdo"}, 164'(ch_data_out), 164'd0);
    endtask

    initial begin
        int b;
        reset = 1'b0; start = 1'b0; abort = 1'b0; instruction = '0;
        offset = '0; dest_offset = '0; filesize = '0; to_full = '0;
        tog_en = 1'b0; flush = 1'b1;
        fork
            monitor();
        join_none
        tick();
        tick();
        @(negedge clk);
        chk_all_zero("reset");
        tick();
        reset = 1'b1;
        do_flush();

        issue(4'd1, 32'd100, 32'd200, 32'd5);
        wait_end("basic");

        do_flush();
        issue(4'd1, 32'd100, 32'd200, 32'd5);
        b = 0;
        while (mp < 1 && b < 50) begin tick(); b++; end
        to_full = 3'b001;
        tick(); tick(); tick(); tick();
        to_full = 3'b000;
        wait_end("stall");
        chk("stall_cycles", 164'(n_stall), 164'd3);

        do_flush();
        tog_en = 1'b1;
        issue(4'd2, 32'd300, 32'd400, 32'd4);
        wait_end("toggle");
        chk("toggle_gets", 164'(n_get1), 164'd4);
        tog_en = 1'b0;

        do_flush();
        issue(4'd0, 32'd10, 32'd20, 32'd5);
        tick(); tick();
        issue(4'd4, 32'd10, 32'd20, 32'd5);
        tick(); tick();
        chk("invalid_err", 164'(n_err), 164'd2);
        chk("invalid_busy", 164'(busy_seen), 164'd0);

        do_flush();
        issue(4'd3, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("zero_done_hi", 164'(acc_done), 164'd1);
        @(negedge clk);
        chk("zero_done_lo", 164'(acc_done), 164'd0);
        chk("zero_ch_en", 164'(ch_seen), 164'd0);

        do_flush();
        issue(4'd1, 32'd500, 32'd600, 32'd5);
        b = 0;
        while (mw < 1 && b < 200) begin tick(); b++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_state", 164'({busy, cmd_err, ch_enable, get_req}), 164'({1'b0, 1'b1, 3'b0, 3'b0}));
        tick(); tick();
        chk("abort_writes", 164'(mw), 164'd2);
        chk("abort_done", 164'(n_done), 164'd0);
        chk("abort_err", 164'(n_err), 164'd1);
        do_flush();
        issue(4'd3, 32'd700, 32'd800, 32'd3);
        wait_end("after_abort");

        do_flush();
        to_full = 3'b001;
        issue(4'd1, 32'd900, 32'd950, 32'd5);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        tick(); tick();
        chk("mid_reset_pulses", 164'({n_done[7:0], n_err[7:0]}), 164'd0);
        reset = 1'b1;
        to_full = 3'b000;
        do_flush();
        issue(4'd2, 32'hFFFF_FFFE, 32'd20, 32'd3);
        wait_end("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
